// File: rtl/i2s_rx_pkg.sv
// rtl/i2s_rx_pkg.sv - shared audio constants and receiver FSM state type
// Purpose: default sample width, synchronizer depth and the I2S receive
//          state enum, shared by i2s_rx and the downstream audio blocks.
// Ports:   none (package).
package i2s_rx_pkg;

  localparam int AUDIO_DATA_WIDTH  = 16;
  localparam int AUDIO_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_SHIFT = 2'd1,
    RX_WAIT  = 2'd2
  } rx_state_e;

endpackage

// File: rtl/i2s_rx_sync_edge.sv
// rtl/i2s_rx_sync_edge.sv - multi-flop synchronizer with rising-edge pulse
// Purpose: bring an asynchronous level into clk_i and flag its 0->1 transitions.
// Ports:   clk_i   - system clock
//          reset_i - synchronous active-high reset
//          d_i     - asynchronous input level
//          rise_o  - one-clk pulse when the synchronized level goes 0->1
module sync_edge
  import i2s_rx_pkg::*;
#(
  parameter int STAGES = AUDIO_SYNC_STAGES
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S receiver producing paired left/right samples
// Purpose: deserialize an MSB-first I2S stream into signed left/right words,
//          strobing sample_valid once per complete left+right frame and
//          flagging short or orphaned slots on frame_error.
// Ports:   clk          - system clock (>= 8x BCLK)
//          reset        - synchronous active-high reset
//          i2s_bclk     - asynchronous bit clock
//          i2s_lrclk    - asynchronous word select (0 = left, 1 = right)
//          i2s_sd       - asynchronous serial data
//          left_sample  - last complete left word
//          right_sample - last complete right word
//          sample_valid - one-clk pulse when both samples update
//          frame_error  - one-clk pulse on short or orphaned slot
module i2s_rx
  import i2s_rx_pkg::*;
#(
  parameter int DATA_WIDTH  = AUDIO_DATA_WIDTH,
  parameter int SYNC_STAGES = AUDIO_SYNC_STAGES
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i2s_bclk,
  input  logic                         i2s_lrclk,
  input  logic                         i2s_sd,
  output logic signed [DATA_WIDTH-1:0] left_sample,
  output logic signed [DATA_WIDTH-1:0] right_sample,
  output logic                         sample_valid,
  output logic                         frame_error
);

  localparam int                CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic                   bclk_rise;
  logic [SYNC_STAGES-1:0] lr_sync_q;
  logic [SYNC_STAGES-1:0] sd_sync_q;
  logic                   lr_s;
  logic                   sd_s;

  rx_state_e              state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  // MSB is never needed: the finished word is formed from these bits plus sd.
  logic [DATA_WIDTH-2:0]  shift_q, shift_d;
  logic [DATA_WIDTH-1:0]  left_stage_q, left_stage_d;
  logic                   staged_q, staged_d;
  logic                   channel_q, channel_d;
  logic                   lr_prev_q, lr_prev_d;
  // Until one BCLK rise has recorded lrclk there is no "previous" value to
  // compare against, so a mid-slot lrclk level after reset is not an edge.
  logic                   lr_seen_q, lr_seen_d;
  logic [DATA_WIDTH-1:0]  left_out_q, left_out_d;
  logic [DATA_WIDTH-1:0]  right_out_q, right_out_d;
  logic                   valid_q, valid_d;
  logic                   error_q, error_d;

  logic                   lr_change;
  logic                   data_bit;
  logic                   word_done;
  logic [DATA_WIDTH-1:0]  full_word;

  sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_bclk_sync (
    .clk_i   (clk),
    .reset_i (reset),
    .d_i     (i2s_bclk),
    .rise_o  (bclk_rise)
  );

  assign lr_s      = lr_sync_q[SYNC_STAGES-1];
  assign sd_s      = sd_sync_q[SYNC_STAGES-1];
  assign lr_change = bclk_rise & lr_seen_q & (lr_s != lr_prev_q);
  assign data_bit  = bclk_rise & ~lr_change;
  assign word_done = (state_q == RX_SHIFT) & data_bit & (bit_cnt_q == LAST_BIT);
  assign full_word = {shift_q, sd_s};

  always_ff @(posedge clk) begin
    if (reset) begin
      lr_sync_q    <= '0;
      sd_sync_q    <= '0;
      state_q      <= RX_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      left_stage_q <= '0;
      staged_q     <= 1'b0;
      channel_q    <= 1'b0;
      lr_prev_q    <= 1'b0;
      lr_seen_q    <= 1'b0;
      left_out_q   <= '0;
      right_out_q  <= '0;
      valid_q      <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      lr_sync_q    <= {lr_sync_q[SYNC_STAGES-2:0], i2s_lrclk};
      sd_sync_q    <= {sd_sync_q[SYNC_STAGES-2:0], i2s_sd};
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      left_stage_q <= left_stage_d;
      staged_q     <= staged_d;
      channel_q    <= channel_d;
      lr_prev_q    <= lr_prev_d;
      lr_seen_q    <= lr_seen_d;
      left_out_q   <= left_out_d;
      right_out_q  <= right_out_d;
      valid_q      <= valid_d;
      error_q      <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (lr_change) state_d = RX_SHIFT;
      RX_SHIFT: begin
        if (lr_change)      state_d = RX_SHIFT;
        else if (word_done) state_d = RX_WAIT;
      end
      RX_WAIT:  if (lr_change) state_d = RX_SHIFT;
      default:  state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    left_stage_d = left_stage_q;
    staged_d     = staged_q;
    channel_d    = channel_q;
    lr_prev_d    = lr_prev_q;
    lr_seen_d    = lr_seen_q;
    left_out_d   = left_out_q;
    right_out_d  = right_out_q;
    valid_d      = 1'b0;
    error_d      = 1'b0;

    if (bclk_rise) begin
      lr_prev_d = lr_s;
      lr_seen_d = 1'b1;
    end

    if (lr_change) begin
      // Delay-slot bit: restart the word for the new channel, bit not kept.
      bit_cnt_d = '0;
      shift_d   = '0;
      channel_d = lr_s;
      if (state_q == RX_SHIFT) begin
        error_d = 1'b1;
        if (!channel_q) staged_d = 1'b0;
      end
    end else if ((state_q == RX_SHIFT) && data_bit) begin
      shift_d   = full_word[DATA_WIDTH-2:0];
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
      if (word_done) begin
        if (!channel_q) begin
          left_stage_d = full_word;
          staged_d     = 1'b1;
        end else if (staged_q) begin
          left_out_d  = left_stage_q;
          right_out_d = full_word;
          valid_d     = 1'b1;
          staged_d    = 1'b0;
        end else begin
          error_d = 1'b1;
        end
      end
    end

    valid_d = valid_d & ~error_d;
  end

  assign left_sample  = left_out_q;
  assign right_sample = right_out_q;
  assign sample_valid = valid_q;
  assign frame_error  = error_q;

endmodule

// File: tb/tb_i2s_rx.sv
// tb/tb_i2s_rx.sv - self-checking bench for i2s_rx
// Purpose: drive I2S frames (BCLK = clk/8) and compare captured samples and
//          error pulses against frame-level expectations.
// Ports:   none (top-level bench).
module tb_i2s_rx;
  import i2s_rx_pkg::*;

  localparam int DW = AUDIO_DATA_WIDTH;
  localparam int SS = AUDIO_SYNC_STAGES;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 i2s_bclk = 1'b0;
  logic                 i2s_lrclk = 1'b1;
  logic                 i2s_sd = 1'b0;
  logic signed [DW-1:0] left_sample;
  logic signed [DW-1:0] right_sample;
  logic                 sample_valid;
  logic                 frame_error;

  i2s_rx #(
    .DATA_WIDTH  (DW),
    .SYNC_STAGES (SS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_sd       (i2s_sd),
    .left_sample  (left_sample),
    .right_sample (right_sample),
    .sample_valid (sample_valid),
    .frame_error  (frame_error)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_fail   = 0;
  int     n_valid  = 0;
  int     n_err    = 0;
  int     n_both   = 0;
  int     n_hold   = 0;
  int     got_l[$];
  int     got_r[$];
  int     exp_l[$];
  int     exp_r[$];
  longint rise_t   = 0;
  longint valid_t  = 0;
  bit     rst_prev = 1'b1;
  logic signed [DW-1:0] prev_l = '0;
  logic signed [DW-1:0] prev_r = '0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sample_valid) begin
      n_valid++;
      got_l.push_back(int'(left_sample));
      got_r.push_back(int'(right_sample));
      valid_t = $time;
    end
    if (frame_error) n_err++;
    if (sample_valid && frame_error) n_both++;
    if (!sample_valid && !reset && !rst_prev &&
        (left_sample != prev_l || right_sample != prev_r)) n_hold++;
    prev_l   = left_sample;
    prev_r   = right_sample;
    rst_prev = reset;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic l, input logic d, input bit mark);
    i2s_lrclk = l;
    i2s_sd    = d;
    i2s_bclk  = 1'b0;
    repeat (4) @(negedge clk);
    i2s_bclk = 1'b1;
    if (mark) rise_t = $time;
    repeat (4) @(negedge clk);
  endtask

  // One slot: delay-slot bit, nbits data bits MSB first, then junk bits.
  task automatic send_slot(input logic l, input logic [DW-1:0] w, input int nbits,
                           input int njunk, input bit mark_last);
    send_bit(l, 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(l, w[DW-1-i], mark_last && (i == DW - 1));
    for (int i = 0; i < njunk; i++) send_bit(l, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int junk);
    send_slot(1'b0, l, DW, junk, 1'b0);
    send_slot(1'b1, r, DW, junk, 1'b1);
    exp_l.push_back(int'($signed(l)));
    exp_r.push_back(int'($signed(r)));
  endtask

  task automatic compare_samples(input string tag);
    check_eq({tag, "_count"}, got_l.size(), exp_l.size());
    for (int i = 0; i < got_l.size() && i < exp_l.size(); i++) begin
      check_eq($sformatf("%s_left%0d", tag, i), got_l[i], exp_l[i]);
      check_eq($sformatf("%s_right%0d", tag, i), got_r[i], exp_r[i]);
    end
    got_l.delete(); got_r.delete(); exp_l.delete(); exp_r.delete();
  endtask

  initial begin
    int e0, v0, exp_err, mode, cut, junk;
    logic [DW-1:0] wl, wr;

    // Reset held 5 clks.
    repeat (5) @(negedge clk);
    check_eq("rst_left", left_sample, 0);
    check_eq("rst_right", right_sample, 0);
    check_eq("rst_valid", sample_valid, 0);
    check_eq("rst_error", frame_error, 0);
    reset = 1'b0;

    // Partial right slot after release.
    for (int i = 0; i < 6; i++) send_bit(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    repeat (4) @(negedge clk);
    check_eq("partial_valid", n_valid, 0);
    check_eq("partial_error", n_err, 0);

    // 16-bit slots.
    send_frame(16'h1234, 16'hFEDC, 0);
    repeat (4) @(negedge clk);
    check_eq("f16_valid", n_valid, 1);
    check_eq("f16_latency", valid_t - rise_t, longint'((SS + 1) * 10));
    compare_samples("f16");
    check_eq("f16_error", n_err, 0);

    // 32-bit slots with junk tail.
    send_frame(16'h7FFF, 16'h8000, 16);
    repeat (4) @(negedge clk);
    check_eq("f32_valid", n_valid, 2);
    compare_samples("f32");
    check_eq("f32_error", n_err, 0);

    // Short left slot, then orphan right.
    e0 = n_err; v0 = n_valid;
    send_slot(1'b0, 16'($urandom), 10, 0, 1'b0);
    send_slot(1'b1, 16'd1000, DW, 0, 1'b0);
    repeat (4) @(negedge clk);
    check_eq("short_error", n_err - e0, 2);
    check_eq("short_valid", n_valid - v0, 0);
    check_eq("short_left_hold", left_sample, 32767);
    check_eq("short_right_hold", right_sample, -32768);

    // Reset in the middle of a right slot.
    send_slot(1'b0, 16'h1111, DW, 0, 1'b0);
    send_slot(1'b1, 16'h2222, 8, 0, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("midrst_left", left_sample, 0);
    check_eq("midrst_right", right_sample, 0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    v0 = n_valid;
    send_frame(16'd1000, 16'($signed(-2000)), 0);
    repeat (4) @(negedge clk);
    check_eq("midrst_frame1_valid", n_valid - v0, 1);
    v0 = n_valid;
    send_frame(16'd5000, 16'd0, 0);
    repeat (4) @(negedge clk);
    check_eq("midrst_frame2_valid", n_valid - v0, 1);
    compare_samples("midrst");

    // Randomized frames: normal, short left (short + orphan), short right.
    e0 = n_err; exp_err = 0;
    for (int f = 0; f < 24; f++) begin
      mode = $urandom_range(0, 4);
      junk = $urandom_range(0, 6);
      wl   = 16'($urandom);
      wr   = 16'($urandom);
      if (mode == 3) begin
        cut = $urandom_range(1, DW - 1);
        send_slot(1'b0, wl, cut, 0, 1'b0);
        send_slot(1'b1, wr, DW, junk, 1'b0);
        exp_err += 2;
      end else if (mode == 4) begin
        cut = $urandom_range(1, DW - 1);
        send_slot(1'b0, wl, DW, junk, 1'b0);
        send_slot(1'b1, wr, cut, 0, 1'b0);
        exp_err += 1;
      end else begin
        send_frame(wl, wr, junk);
      end
    end
    send_frame(16'($urandom), 16'($urandom), 0);
    repeat (4) @(negedge clk);
    check_eq("rand_error", n_err - e0, exp_err);
    compare_samples("rand");
    check_eq("valid_error_overlap", n_both, 0);
    check_eq("output_hold", n_hold, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, meaning the sample width captured per channel.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth on the I2S inputs.
REQ-003 The block SHALL have port clk, input, 1 bit: the system clock; one clock only; clk frequency >= 8x BCLK.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port i2s_bclk, input, 1 bit: I2S bit clock, asynchronous to clk.
REQ-006 The block SHALL have port i2s_lrclk, input, 1 bit: word select, asynchronous; 0 = left, 1 = right.
REQ-007 The block SHALL have port i2s_sd, input, 1 bit: serial data, MSB first, asynchronous.
REQ-008 The block SHALL have port left_sample, output, DATA_WIDTH bits, signed: last complete left word.
REQ-009 The block SHALL have port right_sample, output, DATA_WIDTH bits, signed: last complete right word.
REQ-010 The block SHALL have port sample_valid, output, 1 bit: one-clk pulse when left_sample/right_sample update; it is the sample strobe for the downstream iir_filter latest_sample input.
REQ-011 The block SHALL have port frame_error, output, 1 bit: one-clk pulse on a short or orphaned slot.

Function
REQ-012 i2s_bclk, i2s_lrclk and i2s_sd SHALL each pass through SYNC_STAGES flops; all logic SHALL use only the synchronized copies.
REQ-013 A BCLK rise event SHALL be a single-clk pulse when synchronized bclk is 1 and was 0 on the previous clk; lrclk and sd SHALL be sampled only on that event.
REQ-014 The FSM SHALL have states IDLE, SHIFT and WAIT.
REQ-015 IDLE: the FSM SHALL ignore data until the first BCLK rise where sampled lrclk differs from the previous sampled lrclk, then go to SHIFT; this discards the partial frame after reset.
REQ-016 An lrclk change at a BCLK rise SHALL mark the I2S one-bit delay slot: the FSM SHALL clear bit_cnt and latch channel = new lrclk, and that bit SHALL NOT be shifted in.
REQ-017 SHIFT: each later BCLK rise SHALL shift sd into the LSB of the shift register and increment bit_cnt.
REQ-018 On the DATA_WIDTH-th bit the FSM SHALL go to WAIT. The completed word SHALL go to a left staging register if channel = 0. If channel = 1 and a left word is staged, both left_sample and right_sample SHALL load on the next clk.
REQ-019 WAIT: extra slot bits (e.g. a 32-bit slot) SHALL be ignored until the next lrclk change, which re-enters SHIFT as per REQ-016.
REQ-020 sample_valid SHALL pulse high for exactly one clk, in the same cycle in which left_sample and right_sample take their new values. This is 1 clk after the clk containing the 16th right-channel BCLK rise. The left staged flag SHALL then clear.
REQ-021 Outputs SHALL hold their values between sample_valid pulses.
REQ-022 Short slot: an lrclk change during SHIFT with bit_cnt < DATA_WIDTH SHALL pulse frame_error and discard the partial word. The FSM SHALL restart SHIFT for the new channel per REQ-016; left_sample and right_sample SHALL be unchanged.
REQ-023 Orphan right: a completed right word with no staged left SHALL pulse frame_error, SHALL NOT pulse sample_valid, and SHALL be discarded.
REQ-024 A short left slot SHALL clear the staged-left flag.
REQ-025 sample_valid and frame_error SHALL never be high in the same cycle; if both apply, frame_error wins.
REQ-026 Bit order SHALL be MSB first; the output SHALL be the raw two's-complement word with no scaling.

Reset
REQ-027 While reset is high at a clk edge: state = IDLE, bit_cnt = 0, and the shift, staging and output registers = 0.
REQ-028 While reset is high at a clk edge: sample_valid = 0, frame_error = 0, staged flag = 0, and the synchronizer flops = 0.
REQ-029 Reset asserted mid-word SHALL discard all in-flight data; after release, capture SHALL resume only per REQ-015.

Structure
REQ-030 DATA_WIDTH default, the FSM state enum type and the sync-depth constant SHALL live in the shared audio package used by iir_filter.
REQ-031 One sub-module SHALL be used: sync_edge, which provides the SYNC_STAGES synchronizer plus rise-edge pulse, instanced for bclk. lrclk and sd SHALL use plain synchronizers.

Verification
REQ-032 Reset held 5 clks -> all outputs 0 and no pulses; a partial right slot driven after release -> no sample_valid and no frame_error.
REQ-033 16-bit slots, left = 16'h1234, right = 16'hFEDC (BCLK = clk/8) -> one sample_valid pulse; left_sample = 4660 and right_sample = -292 on the same cycle.
REQ-034 32-bit slots, left = 16'h7FFF then 16 junk bits, right = 16'h8000 then 16 junk bits -> left_sample = 32767, right_sample = -32768; junk bits ignored.
REQ-035 Left slot cut after 10 bits, then a full right slot of 1000 -> frame_error pulses twice (short slot, then orphan right); outputs unchanged; no sample_valid.
REQ-036 Reset asserted at bit 8 of a right slot -> outputs 0; the following two complete frames (1000/-2000, then 5000/0) -> exactly one sample_valid per frame with matching values.
REQ-037 Stream of 8 frames into i2s_rx -> iir_filter with b0 = 1.0 -> iir_filter output tracks left_sample 2 clks after each sample_valid.
